image_blitter: RTL and testbench
================================

// Module: image_blitter
// PURPOSE
//   Copies a W x H rectangle of 5-bit palette indices from an image ROM (640x480,
//   registered read, 1-cycle latency) into a frame-buffer RAM, one pixel per clock.
//   It drives the ROM read_address side, consumes the ROM data, and issues frame-buffer writes.
//   Sits between the image ROMs (title/start screens, sprites) and the frame buffer feeding VGA.
// PARAMETERS
//   SRC_W   640    source image width in pixels
//   SRC_H   480    source image height in pixels
//   DST_W   640    frame-buffer width in pixels
//   DST_H   480    frame-buffer height in pixels
//   ADDR_W  19     address width, source and destination
//   PIX_W   5      palette-index width
//   KEY     5'h00  transparent colour index
// PORTS
//   Clk       in   1       system clock, all logic on posedge
//   Reset     in   1       synchronous, active-high
//   start     in   1       request a blit; sampled only in IDLE
//   src_x0    in   10      source rectangle origin x
//   src_y0    in   10      source rectangle origin y
//   dst_x0    in   10      destination origin x
//   dst_y0    in   10      destination origin y
//   blit_w    in   10      rectangle width (0 allowed)
//   blit_h    in   10      rectangle height (0 allowed)
//   key_en    in   1       1 = skip writes of pixels equal to KEY
//   src_addr  out  ADDR_W  ROM read address (registered)
//   src_data  in   PIX_W   ROM data, valid 1 cycle after src_addr
//   fb_addr   out  ADDR_W  frame-buffer write address (registered)
//   fb_data   out  PIX_W   frame-buffer write data (registered)
//   fb_we     out  1       frame-buffer write enable (registered)
//   busy      out  1       high while a blit is in progress
//   done      out  1       1-cycle completion pulse
// BEHAVIOUR
// - Reset: state=IDLE. src_addr, fb_addr, fb_data = 0. fb_we, busy, done = 0.
// - Reset mid-blit: abort at that edge, fb_we=0 next cycle, no done pulse.
// - States: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
// - IDLE + start=1 at edge E0:
//   - Latch all operands.
//   - If blit_w==0 or blit_h==0: go to DONE (done high in cycle 1, no writes).
//   - Else go to RUN with col=row=0.
// - start while not IDLE is ignored. Operand changes after E0 are ignored.
// - RUN: pixel k (raster order, k=0..N-1, N=w*h) is presented on src_addr during cycle k+1.
//   - col increments each edge. On col==w-1, col=0 and row++.
//   - After pixel N-1 is issued: go to FLUSH for 2 cycles.
// - Address arithmetic uses no multipliers, only incremental row bases (+SRC_W / +DST_W).
//   - src_addr = (src_y0+row)*SRC_W + src_x0+col
//   - fb_addr = (dst_y0+row)*DST_W + dst_x0+col
// - Write pipeline: the src_data for pixel k is registered into fb_data at edge E(k+2).
//   - fb_addr/fb_we for pixel k are valid during cycle k+3 (fb_addr delayed 2 stages).
// - Suppress the write (fb_we=0, pixel still consumes its cycle) if any of:
//   - dest x>=DST_W or dest y>=DST_H (clip);
//   - source x>=SRC_W or y>=SRC_H (src_addr forced to 0);
//   - key_en=1 and src_data==KEY.
// - Timing: busy=1 in cycles 1..N+2. done=1 and busy=0 in cycle N+3, then IDLE.
// - fb_we=0 whenever not writing a valid pixel. fb_addr/fb_data hold when fb_we=0.
// - Coordinate sums are 11 bits wide. There is no wrap-around: overflow counts as out of range.
// TESTING
// - 2x2, src (0,0), dst (10,5), ROM[0]=3, ROM[1]=4, ROM[640]=5, ROM[641]=6, key_en=0
//   -> writes (3210,3), (3211,4), (3850,5), (3851,6) in cycles 3-6; done in cycle 7.
// - Same as above but ROM[1]=0, key_en=1 -> no write to 3211; the other 3 writes occur;
//   done still in cycle 7.
// - Clip: dst (638,0), w=4, h=1 -> writes to 638 and 639 only; busy cycles 1-6; done in cycle 7.
// - blit_w=0, start=1 -> no fb_we; done in cycle 1; busy never high.
// - start pulsed during RUN -> ignored, only one done.
// - Reset at cycle 3 of a 4x4 blit -> fb_we=0, busy=0 next cycle; no done;
//   a new start is accepted afterwards.

Source files
------------

// File: rtl/image_blitter.sv
// image_blitter
//   Copies a W x H rectangle of palette indices from a registered-read image ROM into a
//   frame-buffer RAM, one pixel per clock, with destination clipping, source range checking
//   and optional colour-key transparency.
//
// Ports
//   clk_i           system clock, all logic on posedge
//   reset_i         synchronous, active-high reset
//   start_i         request a blit; only sampled while idle
//   src_x0_i/y0_i   source rectangle origin
//   dst_x0_i/y0_i   destination origin
//   blit_w_i/h_i    rectangle size (zero allowed, finishes without writes)
//   key_en_i        1 = do not write pixels equal to Key
//   src_addr_o      ROM read address (registered)
//   src_data_i      ROM data, valid one cycle after src_addr_o
//   fb_addr_o       frame-buffer write address (registered)
//   fb_data_o       frame-buffer write data (registered)
//   fb_we_o         frame-buffer write enable (registered)
//   busy_o          high while a blit is in progress
//   done_o          one-cycle completion pulse
module image_blitter #(
  parameter int unsigned     SrcW  = 640,
  parameter int unsigned     SrcH  = 480,
  parameter int unsigned     DstW  = 640,
  parameter int unsigned     DstH  = 480,
  parameter int unsigned     AddrW = 19,
  parameter int unsigned     PixW  = 5,
  parameter logic [PixW-1:0] Key   = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [9:0]       src_x0_i,
  input  logic [9:0]       src_y0_i,
  input  logic [9:0]       dst_x0_i,
  input  logic [9:0]       dst_y0_i,
  input  logic [9:0]       blit_w_i,
  input  logic [9:0]       blit_h_i,
  input  logic             key_en_i,
  output logic [AddrW-1:0] src_addr_o,
  input  logic [PixW-1:0]  src_data_i,
  output logic [AddrW-1:0] fb_addr_o,
  output logic [PixW-1:0]  fb_data_o,
  output logic             fb_we_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  // Range limits at coordinate width so comparisons stay width-matched.
  localparam logic [10:0]      SrcWC = 11'(SrcW);
  localparam logic [10:0]      SrcHC = 11'(SrcH);
  localparam logic [10:0]      DstWC = 11'(DstW);
  localparam logic [10:0]      DstHC = 11'(DstH);
  localparam logic [AddrW-1:0] SrcWA = AddrW'(SrcW);
  localparam logic [AddrW-1:0] DstWA = AddrW'(DstW);

  // Constant-coefficient product built from shifts and adds; only used to seed the row
  // bases at launch, after which the bases advance by one row width per row.
  function automatic logic [AddrW-1:0] mul_const(input logic [9:0] y, input int unsigned k);
    logic [AddrW-1:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (AddrW'(y) << i);
    end
    return acc;
  endfunction

  // FSM
  state_e state_q, state_d;
  logic   flush_q, flush_d;
  logic   last_q, last_d;      // final pixel has already been issued

  // Latched operands
  logic [9:0] src_x0_q, src_x0_d;
  logic [9:0] src_y0_q, src_y0_d;
  logic [9:0] dst_x0_q, dst_x0_d;
  logic [9:0] dst_y0_q, dst_y0_d;
  logic [9:0] w_q, w_d;
  logic [9:0] h_q, h_d;
  logic       key_en_q, key_en_d;

  // Raster walk: position of the next pixel to issue, plus its row base addresses
  logic [9:0]       col_q, col_d;
  logic [9:0]       row_q, row_d;
  logic [AddrW-1:0] src_base_q, src_base_d;
  logic [AddrW-1:0] dst_base_q, dst_base_d;

  // Pipeline: stage 1 is the cycle src_addr is presented, stage 2 is the cycle ROM data
  // returns, and the output registers hold the actual write.
  logic [AddrW-1:0] src_addr_q, src_addr_d;
  logic             v1_q, v1_d;
  logic             ok1_q, ok1_d;
  logic [AddrW-1:0] dst1_q, dst1_d;
  logic             v2_q, v2_d;
  logic             ok2_q, ok2_d;
  logic [AddrW-1:0] dst2_q, dst2_d;
  logic [AddrW-1:0] fb_addr_q, fb_addr_d;
  logic [PixW-1:0]  fb_data_q, fb_data_d;
  logic             fb_we_q, fb_we_d;

  // Current-pixel view. While idle, pixel 0 is issued on the launch edge straight from the
  // input operands, so the view selects inputs there and latched state otherwise.
  logic             idle;
  logic [9:0]       op_sx0, op_sy0, op_dx0, op_dy0, op_w, op_h;
  logic [9:0]       cur_col, cur_row;
  logic [AddrW-1:0] cur_sbase, cur_dbase;
  logic [10:0]      sx, sy, dx, dy;
  logic             src_ok, dst_ok;
  logic [AddrW-1:0] src_lin, dst_lin;
  logic             col_wrap, is_last;
  logic             issue;
  logic             write_now;

  always_comb begin
    idle      = (state_q == StIdle);
    op_sx0    = idle ? src_x0_i : src_x0_q;
    op_sy0    = idle ? src_y0_i : src_y0_q;
    op_dx0    = idle ? dst_x0_i : dst_x0_q;
    op_dy0    = idle ? dst_y0_i : dst_y0_q;
    op_w      = idle ? blit_w_i : w_q;
    op_h      = idle ? blit_h_i : h_q;
    cur_col   = idle ? 10'd0 : col_q;
    cur_row   = idle ? 10'd0 : row_q;
    cur_sbase = idle ? mul_const(src_y0_i, SrcW) : src_base_q;
    cur_dbase = idle ? mul_const(dst_y0_i, DstW) : dst_base_q;

    // 11-bit sums cannot overflow, so anything past the image edge is simply out of range.
    sx = {1'b0, op_sx0} + {1'b0, cur_col};
    sy = {1'b0, op_sy0} + {1'b0, cur_row};
    dx = {1'b0, op_dx0} + {1'b0, cur_col};
    dy = {1'b0, op_dy0} + {1'b0, cur_row};

    src_ok  = (sx < SrcWC) && (sy < SrcHC);
    dst_ok  = (dx < DstWC) && (dy < DstHC);
    src_lin = cur_sbase + AddrW'(sx);
    dst_lin = cur_dbase + AddrW'(dx);

    col_wrap = (cur_col == op_w - 10'd1);
    is_last  = col_wrap && (cur_row == op_h - 10'd1);
  end

  // Next-state and control
  always_comb begin
    state_d    = state_q;
    flush_d    = 1'b0;
    last_d     = last_q;
    src_x0_d   = src_x0_q;
    src_y0_d   = src_y0_q;
    dst_x0_d   = dst_x0_q;
    dst_y0_d   = dst_y0_q;
    w_d        = w_q;
    h_d        = h_q;
    key_en_d   = key_en_q;
    col_d      = col_q;
    row_d      = row_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    issue      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          src_x0_d = src_x0_i;
          src_y0_d = src_y0_i;
          dst_x0_d = dst_x0_i;
          dst_y0_d = dst_y0_i;
          w_d      = blit_w_i;
          h_d      = blit_h_i;
          key_en_d = key_en_i;
          if ((blit_w_i == 10'd0) || (blit_h_i == 10'd0)) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            issue   = 1'b1;
          end
        end
      end
      StRun: begin
        if (last_q) begin
          state_d = StFlush;
        end else begin
          issue = 1'b1;
        end
      end
      StFlush: begin
        // Two cycles: lets the last pixel pass through the ROM and write stages.
        flush_d = 1'b1;
        if (flush_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (issue) begin
      last_d = is_last;
      if (col_wrap) begin
        col_d      = 10'd0;
        row_d      = cur_row + 10'd1;
        src_base_d = cur_sbase + SrcWA;
        dst_base_d = cur_dbase + DstWA;
      end else begin
        col_d      = cur_col + 10'd1;
        row_d      = cur_row;
        src_base_d = cur_sbase;
        dst_base_d = cur_dbase;
      end
    end
  end

  // Write pipeline
  always_comb begin
    src_addr_d = src_addr_q;
    v1_d       = issue;
    ok1_d      = ok1_q;
    dst1_d     = dst1_q;
    if (issue) begin
      src_addr_d = src_ok ? src_lin : '0;
      ok1_d      = src_ok && dst_ok;
      dst1_d     = dst_lin;
    end

    v2_d   = v1_q;
    ok2_d  = ok1_q;
    dst2_d = dst1_q;

    // ROM data for the stage-2 pixel is on src_data_i now.
    write_now = v2_q && ok2_q && !(key_en_q && (src_data_i == Key));
    fb_we_d   = write_now;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    if (write_now) begin
      fb_addr_d = dst2_q;
      fb_data_d = src_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      flush_q    <= 1'b0;
      last_q     <= 1'b0;
      src_x0_q   <= '0;
      src_y0_q   <= '0;
      dst_x0_q   <= '0;
      dst_y0_q   <= '0;
      w_q        <= '0;
      h_q        <= '0;
      key_en_q   <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      src_addr_q <= '0;
      v1_q       <= 1'b0;
      ok1_q      <= 1'b0;
      dst1_q     <= '0;
      v2_q       <= 1'b0;
      ok2_q      <= 1'b0;
      dst2_q     <= '0;
      fb_addr_q  <= '0;
      fb_data_q  <= '0;
      fb_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      last_q     <= last_d;
      src_x0_q   <= src_x0_d;
      src_y0_q   <= src_y0_d;
      dst_x0_q   <= dst_x0_d;
      dst_y0_q   <= dst_y0_d;
      w_q        <= w_d;
      h_q        <= h_d;
      key_en_q   <= key_en_d;
      col_q      <= col_d;
      row_q      <= row_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      src_addr_q <= src_addr_d;
      v1_q       <= v1_d;
      ok1_q      <= ok1_d;
      dst1_q     <= dst1_d;
      v2_q       <= v2_d;
      ok2_q      <= ok2_d;
      dst2_q     <= dst2_d;
      fb_addr_q  <= fb_addr_d;
      fb_data_q  <= fb_data_d;
      fb_we_q    <= fb_we_d;
    end
  end

  assign src_addr_o = src_addr_q;
  assign fb_addr_o  = fb_addr_q;
  assign fb_data_o  = fb_data_q;
  assign fb_we_o    = fb_we_q;
  assign busy_o     = (state_q == StRun) || (state_q == StFlush);
  assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_image_blitter.sv
// Scoreboard bench for image_blitter: stimulus pushes expected writes, done pulses and the
// busy window; a negedge monitor compares them against the DUT outputs cycle by cycle.
module tb_image_blitter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  src_x0, src_y0, dst_x0, dst_y0, blit_w, blit_h;
  logic        key_en;
  logic [18:0] src_addr;
  logic [4:0]  src_data;
  logic [18:0] fb_addr;
  logic [4:0]  fb_data;
  logic        fb_we;
  logic        busy;
  logic        done;

  image_blitter dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .src_x0_i   (src_x0),
    .src_y0_i   (src_y0),
    .dst_x0_i   (dst_x0),
    .dst_y0_i   (dst_y0),
    .blit_w_i   (blit_w),
    .blit_h_i   (blit_h),
    .key_en_i   (key_en),
    .src_addr_o (src_addr),
    .src_data_i (src_data),
    .fb_addr_o  (fb_addr),
    .fb_data_o  (fb_data),
    .fb_we_o    (fb_we),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read image ROM
  logic [4:0] rom [0:524287];
  always @(posedge clk) src_data <= rom[src_addr];

  // Cycle n of a blit is the interval where cyc == base + n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  blo = 1;
  int  bhi = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  wr_t mw;
  bit  exp_busy;

  task automatic exp_wr(input int c, input int a, input int d);
    wr_t w;
    w.cyc  = c;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  // Called at a negedge; the following posedge is the launch edge. Returns at base+1.
  task automatic launch(input int sx, input int sy, input int dx, input int dy, input int w,
                        input int h, input logic key, output int base);
    src_x0 = 10'(sx);
    src_y0 = 10'(sy);
    dst_x0 = 10'(dx);
    dst_y0 = 10'(dy);
    blit_w = 10'(w);
    blit_h = 10'(h);
    key_en = key;
    start  = 1'b1;
    base   = cyc;
    if (w * h > 0) begin
      blo = base + 1;
      bhi = base + w * h + 2;
      dq.push_back(base + w * h + 3);
    end else begin
      dq.push_back(base + 1);
    end
    @(negedge clk);
    start  = 1'b0;
    src_x0 = 10'($urandom);
    src_y0 = 10'($urandom);
    dst_x0 = 10'($urandom);
    dst_y0 = 10'($urandom);
    blit_w = 10'($urandom);
    blit_h = 10'($urandom);
    key_en = ~key;
  endtask

  // Reference: raster walk with direct coordinate arithmetic
  task automatic model(input int sx, input int sy, input int dx, input int dy, input int w,
                       input int h, input logic key, input int base);
    int k;
    int d;
    k = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if ((sx + c < 640) && (sy + r < 480) && (dx + c < 640) && (dy + r < 480)) begin
          d = int'(rom[(sy + r) * 640 + sx + c]);
          if (!(key && d == 0)) exp_wr(base + k + 3, (dy + r) * 640 + dx + c, d);
        end
        k++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_write: got no write, required addr=%0d data=%0d in cycle %0d",
                 wq[0].addr, wq[0].data, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (fb_we === 1'b1) begin
        checks++;
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          mw = wq.pop_front();
          if (int'(fb_addr) != mw.addr || int'(fb_data) != mw.data) begin
            failures++;
            $display("FAIL write_value cyc=%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
                     cyc, fb_addr, fb_data, mw.addr, mw.data);
          end
        end else begin
          failures++;
          $display("FAIL unexpected_write cyc=%0d: got addr=%0d data=%0d, required no write",
                   cyc, fb_addr, fb_data);
        end
      end else if (fb_we !== 1'b0) begin
        checks++;
        failures++;
        $display("FAIL fb_we_x cyc=%0d: got %b, required 0 or 1", cyc, fb_we);
      end

      while (dq.size() > 0 && dq[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_done: got no done, required done in cycle %0d", dq[0]);
        void'(dq.pop_front());
      end
      if (done !== 1'b0) begin
        checks++;
        if (done === 1'b1 && dq.size() > 0 && dq[0] == cyc) begin
          void'(dq.pop_front());
        end else begin
          failures++;
          $display("FAIL unexpected_done cyc=%0d: got done=%b, required 0", cyc, done);
        end
      end

      checks++;
      exp_busy = (cyc >= blo) && (cyc <= bhi);
      if (busy !== exp_busy) begin
        failures++;
        $display("FAIL busy cyc=%0d: got %b, required %b", cyc, busy, exp_busy);
      end
    end
  end

  task automatic check_rst(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b;
    for (int a = 0; a < 524288; a++) rom[a] = 5'((a % 31) + 1);
    rom[0]   = 5'd3;
    rom[1]   = 5'd4;
    rom[640] = 5'd5;
    rom[641] = 5'd6;

    reset  = 1'b1;
    start  = 1'b0;
    src_x0 = '0;
    src_y0 = '0;
    dst_x0 = '0;
    dst_y0 = '0;
    blit_w = '0;
    blit_h = '0;
    key_en = 1'b0;
    repeat (3) @(negedge clk);

    check_rst("rst_src_addr", int'(src_addr), 0);
    check_rst("rst_fb_addr", int'(fb_addr), 0);
    check_rst("rst_fb_data", int'(fb_data), 0);
    check_rst("rst_fb_we", (fb_we === 1'b0) ? 0 : 1, 0);
    check_rst("rst_busy", (busy === 1'b0) ? 0 : 1, 0);
    check_rst("rst_done", (done === 1'b0) ? 0 : 1, 0);
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // 2x2 copy
    launch(0, 0, 10, 5, 2, 2, 1'b0, b);
    exp_wr(b + 3, 3210, 3);
    exp_wr(b + 4, 3211, 4);
    exp_wr(b + 5, 3850, 5);
    exp_wr(b + 6, 3851, 6);
    repeat (8) @(negedge clk);

    // Same with colour key on ROM[1]
    rom[1] = 5'd0;
    launch(0, 0, 10, 5, 2, 2, 1'b1, b);
    exp_wr(b + 3, 3210, 3);
    exp_wr(b + 5, 3850, 5);
    exp_wr(b + 6, 3851, 6);
    repeat (8) @(negedge clk);
    rom[1] = 5'd4;

    // Right-edge clip
    launch(0, 0, 638, 0, 4, 1, 1'b0, b);
    exp_wr(b + 3, 638, 3);
    exp_wr(b + 4, 639, 4);
    repeat (8) @(negedge clk);

    // Zero width
    launch(0, 0, 0, 0, 0, 5, 1'b0, b);
    repeat (4) @(negedge clk);

    // Start pulsed during RUN (with a zero width that would finish at once if taken)
    launch(5, 2, 20, 30, 3, 2, 1'b0, b);
    model(5, 2, 20, 30, 3, 2, 1'b0, b);
    @(negedge clk);
    start  = 1'b1;
    blit_w = 10'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // Source partially beyond the image corner
    launch(638, 479, 100, 100, 3, 2, 1'b0, b);
    model(638, 479, 100, 100, 3, 2, 1'b0, b);
    repeat (10) @(negedge clk);

    // Bottom-edge clip
    launch(3, 3, 0, 479, 1, 2, 1'b0, b);
    exp_wr(b + 3, 479 * 640, int'(rom[3 * 640 + 3]));
    repeat (7) @(negedge clk);

    // Reset in cycle 3 of a 4x4 blit: only pixel 0 is written, no done
    launch(0, 0, 0, 0, 4, 4, 1'b0, b);
    exp_wr(b + 3, 0, 3);
    void'(dq.pop_back());
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bhi   = b + 3;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // New start accepted after the abort
    launch(1, 0, 2, 3, 1, 1, 1'b0, b);
    exp_wr(b + 3, 1922, 4);
    repeat (6) @(negedge clk);

    check_rst("pending_writes", wq.size(), 0);
    check_rst("pending_done", dq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
